// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction field positions, FSM states and opcode legality for alu_op_sequencer
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD = 4'b1111;
  localparam logic [3:0] OP_SUB = 4'b1110;
  localparam logic [3:0] OP_INC = 4'b1101;
  localparam logic [3:0] OP_DEC = 4'b1100;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0000;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 8;
  localparam int RS2_MSB = 7;
  localparam int RS2_LSB = 6;
  localparam int CIN_BIT = 5;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WB} state_t;
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_LDI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4x8 register file, two async read ports, one sync write port
module alu_seq_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_we,
  input  logic [1:0] i_wa,
  input  logic [7:0] i_wd,
  input  logic [1:0] i_ra1,
  input  logic [1:0] i_ra2,
  output logic [7:0] o_rd1,
  output logic [7:0] o_rd2
);
  logic [7:0] r_mem [4];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  assign o_rd1 = r_mem[i_ra1];
  assign o_rd2 = r_mem[i_ra2];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts instruction words, drives an external combinational ALU
// and writes its result and carry back to a local register file
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  output logic [3:0]  alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic [1:0]  res_rd,
  output logic        res_err,
  output logic        carry_flag,
  output logic [15:0] instr_count
);
  state_t      r_state, w_next;
  logic [7:0]  r_alu_a, r_alu_b, r_res_data;
  logic [3:0]  r_alu_opcode;
  logic        r_alu_cin, r_res_err, r_carry;
  logic [1:0]  r_res_rd;
  logic [15:0] r_count;
  logic [3:0]  w_op;
  logic [1:0]  w_rd, w_rs1, w_rs2, w_wa;
  logic [7:0]  w_imm, w_rdata1, w_rdata2, w_wd;
  logic        w_cin_sel, w_accept, w_is_ldi, w_legal, w_is_alu, w_issue, w_we;
  assign w_op      = instr[OP_MSB:OP_LSB];
  assign w_rd      = instr[RD_MSB:RD_LSB];
  assign w_rs1     = instr[RS1_MSB:RS1_LSB];
  assign w_rs2     = instr[RS2_MSB:RS2_LSB];
  assign w_cin_sel = instr[CIN_BIT];
  assign w_imm     = instr[IMM_MSB:IMM_LSB];
  assign w_accept  = instr_valid && r_state == ST_IDLE;
  assign w_is_ldi  = w_op == OP_LDI;
  assign w_legal   = is_legal_op(w_op);
  assign w_is_alu  = w_legal && !w_is_ldi;
  assign w_issue   = r_state == ST_ISSUE;
  // LDI writes on the accept edge; ALU results write at the end of ISSUE
  assign w_we = (w_accept && w_is_ldi) || w_issue;
  assign w_wa = w_issue ? r_res_rd : w_rd;
  assign w_wd = w_issue ? alu_out : w_imm;
  alu_seq_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_we  (w_we),
    .i_wa  (w_wa),
    .i_wd  (w_wd),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rdata1),
    .o_rd2 (w_rdata2)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == ST_IDLE  ? (instr_valid ? (w_is_alu ? ST_ISSUE : ST_WB) : ST_IDLE) :
             r_state == ST_ISSUE ? ST_WB : ST_IDLE;
  end
  always_comb begin
    instr_ready = r_state == ST_IDLE;
    res_valid   = r_state == ST_WB;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_alu_a      <= 8'h00;
      r_alu_b      <= 8'h00;
      r_alu_cin    <= 1'b0;
      r_alu_opcode <= OP_LDI;
      r_res_data   <= 8'h00;
      r_res_rd     <= 2'd0;
      r_res_err    <= 1'b0;
      r_carry      <= 1'b0;
      r_count      <= 16'h0000;
    end else begin
      if (w_accept) begin
        r_res_rd   <= w_rd;
        r_res_err  <= !w_legal;
        r_res_data <= w_is_ldi ? w_imm : 8'h00;
        if (w_is_alu) begin
          r_alu_a      <= w_rdata1;
          r_alu_b      <= w_rdata2;
          r_alu_cin    <= w_cin_sel && r_carry;
          r_alu_opcode <= w_op;
        end
      end
      if (w_issue) begin
        r_res_data   <= alu_out;
        r_carry      <= alu_cout;
        r_alu_opcode <= OP_LDI;
      end
      if (w_next == ST_WB) r_count <= r_count + 16'd1;
    end
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_cin     = r_alu_cin;
  assign alu_opcode  = r_alu_opcode;
  assign res_data    = r_res_data;
  assign res_rd      = r_res_rd;
  assign res_err     = r_res_err;
  assign carry_flag  = r_carry;
  assign instr_count = r_count;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random instruction streams against a reference model,
// with a behavioural 8-bit ALU attached to the sequencer
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  alu_a, alu_b, alu_out, res_data;
  logic        alu_cin, alu_cout, res_valid, res_err, carry_flag;
  logic [3:0]  alu_opcode;
  logic [1:0]  res_rd;
  logic [15:0] instr_count;
  int total = 0;
  int bad = 0;
  int m_rf [4];
  int m_c = 0;
  int m_cnt = 0;
  logic [7:0] last_data;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_cout(alu_cout), .res_valid(res_valid), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err), .carry_flag(carry_flag), .instr_count(instr_count)
  );

  always_comb begin
    {alu_cout, alu_out} = 9'h000;
    case (alu_opcode)
      4'b1111: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      4'b1110: {alu_cout, alu_out} = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
      4'b1101: {alu_cout, alu_out} = {1'b0, alu_a} + 9'd1;
      4'b1100: {alu_cout, alu_out} = {1'b0, alu_a} - 9'd1;
      4'b0111: alu_out = alu_a & alu_b;
      4'b0110: alu_out = alu_a | alu_b;
      4'b0101: alu_out = ~alu_a;
      4'b0100: alu_out = alu_a ^ alu_b;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs1, input int rs2, input int cs);
    mk = 16'((op << 12) | (rd << 10) | (rs1 << 8) | (rs2 << 6) | (cs << 5));
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    ldi = 16'((rd << 10) | (imm & 255));
  endfunction

  function automatic bit is_alu(input int op);
    is_alu = op inside {15, 14, 13, 12, 7, 6, 5, 4};
  endfunction

  // Applies one instruction to the model; returns the expected reported value and error flag
  function automatic void model_exec(input logic [15:0] w, output int d, output bit e);
    int op, rd, a, b, cin, r;
    op = int'(w[15:12]); rd = int'(w[11:10]);
    a = m_rf[w[9:8]]; b = m_rf[w[7:6]];
    cin = w[5] ? m_c : 0;
    e = 1'b0; d = 0;
    m_cnt = (m_cnt + 1) % 65536;
    if (op == 0) begin
      d = int'(w[7:0]); m_rf[rd] = d;
    end else if (!is_alu(op)) begin
      e = 1'b1;
    end else begin
      case (op)
        15: r = a + b + cin;
        14: r = a - b - cin;
        13: r = a + 1;
        12: r = a - 1;
        7: r = a & b;
        6: r = a | b;
        5: r = 255 - a;
        default: r = a ^ b;
      endcase
      d = ((r % 256) + 256) % 256;
      m_c = (op >= 12 && (r > 255 || r < 0)) ? 1 : 0;
      m_rf[rd] = d;
    end
  endfunction

  // Called at a falling edge with the sequencer idle; returns at the next idle falling edge
  task automatic run(input logic [15:0] w);
    int ea, eb, ec, ed;
    bit ee, alu;
    alu = is_alu(int'(w[15:12]));
    ea = m_rf[w[9:8]]; eb = m_rf[w[7:6]];
    ec = w[5] ? m_c : 0;
    chk("ready_idle", 16'(instr_ready), 16'd1);
    instr = w; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    model_exec(w, ed, ee);
    if (alu) begin
      chk("ready_issue", 16'(instr_ready), 16'd0);
      chk("valid_issue", 16'(res_valid), 16'd0);
      chk("alu_a", 16'(alu_a), 16'(ea));
      chk("alu_b", 16'(alu_b), 16'(eb));
      chk("alu_cin", 16'(alu_cin), 16'(ec));
      chk("alu_opcode", 16'(alu_opcode), 16'(w[15:12]));
      @(negedge clk);
    end
    chk("res_valid", 16'(res_valid), 16'd1);
    chk("ready_wb", 16'(instr_ready), 16'd0);
    chk("res_data", 16'(res_data), 16'(ed));
    chk("res_rd", 16'(res_rd), 16'(w[11:10]));
    chk("res_err", 16'(res_err), 16'(ee));
    chk("carry", 16'(carry_flag), 16'(m_c));
    chk("count", instr_count, 16'(m_cnt));
    chk("opcode_rest", 16'(alu_opcode), 16'd0);
    last_data = res_data;
    @(negedge clk);
    chk("valid_drop", 16'(res_valid), 16'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    m_c = 0; m_cnt = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_valid", 16'(res_valid), 16'd0);
    chk("rst_alu_a", 16'(alu_a), 16'd0);
    chk("rst_alu_b", 16'(alu_b), 16'd0);
    chk("rst_alu_cin", 16'(alu_cin), 16'd0);
    chk("rst_alu_opcode", 16'(alu_opcode), 16'd0);
    chk("rst_res_data", 16'(res_data), 16'd0);
    chk("rst_res_rd", 16'(res_rd), 16'd0);
    chk("rst_res_err", 16'(res_err), 16'd0);
    chk("rst_carry", 16'(carry_flag), 16'd0);
    chk("rst_count", instr_count, 16'd0);
  endtask

  initial begin
    int pulses, ops [8];
    logic [15:0] w;
    ops = '{15, 14, 13, 12, 7, 6, 5, 4};
    instr = 16'hFFFF; instr_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    do_reset();
    run(ldi(1, 8'hF0));
    run(ldi(2, 8'h20));
    run(mk(15, 3, 1, 2, 0));
    chk("add_lit", 16'(last_data), 16'h0010);
    chk("add_carry_lit", 16'(carry_flag), 16'd1);
    run(mk(15, 3, 0, 0, 1));
    chk("addc_lit", 16'(last_data), 16'h0001);
    run(mk(15, 3, 1, 2, 0));
    run(mk(15, 0, 0, 0, 0));
    chk("add_nocin_lit", 16'(last_data), 16'h0000);
    run(ldi(1, 8'hAA));
    run(mk(5, 2, 1, 0, 0));
    chk("not_lit", 16'(last_data), 16'h0055);
    run(mk(4, 3, 1, 2, 0));
    chk("xor_lit", 16'(last_data), 16'h00FF);
    chk("xor_carry_lit", 16'(carry_flag), 16'd0);
    run(mk(15, 3, 1, 2, 0));
    run(mk(9, 1, 1, 1, 1));
    run(mk(15, 2, 2, 2, 1));
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: w = ldi($urandom_range(0, 3), $urandom_range(0, 255));
        1: w = mk($urandom_range(1, 3) + 8 * $urandom_range(0, 1), $urandom_range(0, 3), 0, 0, 0) | 16'($urandom_range(0, 1023));
        default: w = mk(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      endcase
      run(w);
    end
    do_reset();
    pulses = 0;
    instr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      int d;
      bit e;
      w = mk(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      instr = w;
      chk("b2b_ready1", 16'(instr_ready), 16'd1);
      pulses += int'(res_valid);
      model_exec(w, d, e);
      @(negedge clk);
      chk("b2b_ready2", 16'(instr_ready), 16'd0);
      pulses += int'(res_valid);
      @(negedge clk);
      chk("b2b_ready3", 16'(instr_ready), 16'd0);
      chk("b2b_data", 16'(res_data), 16'(d));
      pulses += int'(res_valid);
      if (k == 7) instr_valid = 1'b0;
      @(negedge clk);
    end
    pulses += int'(res_valid);
    chk("b2b_pulses", 16'(pulses), 16'd8);
    chk("b2b_count", instr_count, 16'd8);
    do_reset();
    run(ldi(1, 8'h11));
    run(ldi(2, 8'h22));
    instr = mk(15, 3, 1, 2, 0); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_in_issue", 16'(alu_opcode), 16'h000F);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    chk("abort_no_valid", 16'(res_valid), 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    m_c = 0; m_cnt = 0;
    run(mk(15, 0, 3, 3, 0));
    run(ldi(0, 8'h7E));
    run(mk(13, 1, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
